// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: single-cycle multiply, 32-step restoring divide,
// with a one-cycle fast path for divide-by-zero and signed overflow.
`ifndef REG_LEN
`define REG_LEN 32
`endif

module muldiv_sequencer (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                flush_i,
    input  logic [2:0]          op_i,
    input  logic [`REG_LEN-1:0] opr_1_i,
    input  logic [`REG_LEN-1:0] opr_2_i,
    output logic                ready_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [`REG_LEN-1:0] result_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] rem_q, rem_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic [31:0] result_q, result_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        accept_s;
    logic        div_zero_s;
    logic        div_ovf_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [63:0] mul_a_s;
    logic [63:0] mul_b_s;
    logic [63:0] prod_s;
    logic [31:0] mul_res_s;
    logic [32:0] rem_sh_s;
    logic [32:0] diff_s;
    logic        sub_ok_s;
    logic [31:0] q_fin_s;
    logic [31:0] r_fin_s;

    assign accept_s   = start_i & ready_q & ~flush_i;
    assign div_zero_s = (opr_2_i == 32'd0);
    assign div_ovf_s  = ~op_i[0] & (opr_1_i == 32'h8000_0000) & (opr_2_i == 32'hFFFF_FFFF);
    assign a_neg_s    = ~op_i[0] & opr_1_i[31];
    assign b_neg_s    = ~op_i[0] & opr_2_i[31];

    // A 64x64 product of the sign/zero-extended operands has the right low 64 bits for every variant.
    assign mul_a_s   = {{32{(op_q != 2'b11) & opa_q[31]}}, opa_q};
    assign mul_b_s   = {{32{~op_q[1] & opb_q[31]}}, opb_q};
    assign prod_s    = mul_a_s * mul_b_s;
    assign mul_res_s = (op_q == 2'b00) ? prod_s[31:0] : prod_s[63:32];

    // opa_q doubles as the dividend/quotient shift register during a divide.
    assign rem_sh_s = {rem_q, opa_q[31]};
    assign diff_s   = rem_sh_s - {1'b0, opb_q};
    assign sub_ok_s = ~diff_s[32];
    assign q_fin_s  = q_neg_q ? (32'd0 - opa_q) : opa_q;
    assign r_fin_s  = r_neg_q ? (32'd0 - rem_q) : rem_q;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept_s) begin
                        op_d = op_i[1:0];
                        if (!op_i[2]) begin
                            opa_d   = opr_1_i;
                            opb_d   = opr_2_i;
                            state_d = S_MUL;
                        end else if (div_zero_s) begin
                            result_d = op_i[1] ? opr_1_i : 32'hFFFF_FFFF;
                            state_d  = S_DONE;
                        end else if (div_ovf_s) begin
                            result_d = op_i[1] ? 32'h0000_0000 : 32'h8000_0000;
                            state_d  = S_DONE;
                        end else begin
                            opa_d   = a_neg_s ? (32'd0 - opr_1_i) : opr_1_i;
                            opb_d   = b_neg_s ? (32'd0 - opr_2_i) : opr_2_i;
                            rem_d   = 32'd0;
                            cnt_d   = 6'd32;
                            q_neg_d = a_neg_s ^ b_neg_s;
                            r_neg_d = a_neg_s;
                            state_d = S_DIV;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_MUL: begin
                    result_d = mul_res_s;
                    state_d  = S_DONE;
                end
                S_DIV: begin
                    if (cnt_q == 6'd0) begin
                        result_d = op_q[1] ? r_fin_s : q_fin_s;
                        state_d  = S_DONE;
                    end else begin
                        rem_d = sub_ok_s ? diff_s[31:0] : rem_sh_s[31:0];
                        opa_d = {opa_q[30:0], sub_ok_s};
                        cnt_d = cnt_q - 6'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
        busy_d  = (state_d == S_MUL) || (state_d == S_DIV);
        done_d  = (state_d == S_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= 2'd0;
            opa_q    <= 32'd0;
            opb_q    <= 32'd0;
            rem_q    <= 32'd0;
            cnt_q    <= 6'd0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= 32'd0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign ready_o  = ready_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst_i;
    logic        start_i;
    logic        flush_i;
    logic [2:0]  op_i;
    logic [31:0] opr_1_i;
    logic [31:0] opr_2_i;
    logic        ready_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_result;

    muldiv_sequencer dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .flush_i  (flush_i),
        .op_i     (op_i),
        .opr_1_i  (opr_1_i),
        .opr_2_i  (opr_2_i),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: RV32M semantics computed with 64-bit integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        if (!op[2]) begin
            sa = (op == 3'b011) ? longint'(a) : longint'(int'(a));
            sb = op[1] ? longint'(b) : longint'(int'(b));
            p  = sa * sb;
            return (op == 3'b000) ? p[31:0] : p[63:32];
        end
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            sa = longint'(int'(a));
            sb = longint'(int'(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        p = op[1] ? (sa % sb) : (sa / sb);
        return p[31:0];
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return 1;
        if (b == 32'd0) return 0;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op (caller is one #1 past an edge with ready_o=1) and wait for its completion.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit idle_after);
        logic [31:0] exp_r;
        int          exp_l, lat, busy_n;
        bit          seen;
        exp_r = ref_result(op, a, b);
        exp_l = exp_lat(op, a, b);
        check("ready_before_start", {31'd0, ready_o}, 32'd1);
        op_i = op; opr_1_i = a; opr_2_i = b; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        op_i = 3'($urandom); opr_1_i = $urandom; opr_2_i = $urandom;
        lat = 0; busy_n = 0; seen = 1'b0;
        while (!seen && lat <= 100) begin
            if (done_o) begin
                seen = 1'b1;
            end else begin
                if (busy_o) busy_n++;
                @(posedge clk); #1;
                lat++;
            end
        end
        check($sformatf("done_seen op%0d", op), {31'd0, seen}, 32'd1);
        check($sformatf("latency op%0d", op), 32'(lat), 32'(exp_l));
        check($sformatf("busy_cycles op%0d", op), 32'(busy_n), 32'(exp_l));
        check($sformatf("result op%0d %h/%h", op, a, b), result_o, exp_r);
        check("busy_at_done", {31'd0, busy_o}, 32'd0);
        check("ready_at_done", {31'd0, ready_o}, 32'd1);
        last_result = exp_r;
        if (idle_after) begin
            @(posedge clk); #1;
            check("done_pulse_width", {31'd0, done_o}, 32'd0);
            check("result_hold", result_o, exp_r);
        end
    endtask

    initial begin
        bit seen_done;
        rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0;
        op_i = 3'd0; opr_1_i = 32'd0; opr_2_i = 32'd0;
        #12;
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        @(negedge clk); rst_i = 1'b0;
        @(posedge clk); #1;

        // Directed cases.
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op(3'b101, 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op(3'b100, 32'd100, 32'd0, 1'b1);
        run_op(3'b111, 32'd100, 32'd0, 1'b1);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

        // Flush on the tenth busy cycle of DIVU 1000/3.
        op_i = 3'b101; opr_1_i = 32'd1000; opr_2_i = 32'd3; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("busy_before_flush", {31'd0, busy_o}, 32'd1);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("flush_busy", {31'd0, busy_o}, 32'd0);
        check("flush_ready", {31'd0, ready_o}, 32'd1);
        check("flush_done", {31'd0, done_o}, 32'd0);
        check("flush_result", result_o, last_result);
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done_o) seen_done = 1'b1;
        end
        check("flush_no_done", {31'd0, seen_done}, 32'd0);
        run_op(3'b000, 32'd6, 32'd7, 1'b1);

        // Flush during the final divide cycle.
        op_i = 3'b100; opr_1_i = 32'd77; opr_2_i = 32'd5; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        check("busy_last_div", {31'd0, busy_o}, 32'd1);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("late_flush_done", {31'd0, done_o}, 32'd0);
        check("late_flush_result", result_o, last_result);
        @(posedge clk); #1;
        check("late_flush_done2", {31'd0, done_o}, 32'd0);

        // Start together with flush is dropped.
        op_i = 3'b000; opr_1_i = 32'd3; opr_2_i = 32'd3; start_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        check("flush_start_busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk); #1;
        check("flush_start_done", {31'd0, done_o}, 32'd0);
        check("flush_start_result", result_o, last_result);

        // Asynchronous reset mid-divide.
        op_i = 3'b101; opr_1_i = 32'd12345; opr_2_i = 32'd7; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_i = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy_o}, 32'd0);
        check("arst_ready", {31'd0, ready_o}, 32'd1);
        check("arst_done", {31'd0, done_o}, 32'd0);
        check("arst_result", result_o, 32'd0);
        @(negedge clk); rst_i = 1'b0;
        @(posedge clk); #1;
        run_op(3'b101, 32'd9, 32'd3, 1'b1);

        // Back-to-back: MUL started in the DONE cycle of DIVU.
        run_op(3'b101, 32'd9, 32'd3, 1'b0);
        run_op(3'b000, 32'd6, 32'd7, 1'b1);

        // Randomized operations, some issued back-to-back.
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  rop;
            logic [31:0] ra, rb;
            rop = 3'($urandom);
            ra  = pick_operand();
            rb  = pick_operand();
            run_op(rop, ra, rb, ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
